// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
//   StFetch/StHold/StDrain : 2-bit fetch FSM encodings
//   NopInst                : bubble instruction (addi x0, x0, 0)
//   ResetPc                : first fetch address after reset
package if_fetch_stage_pkg;

  localparam logic [1:0] StFetch = 2'd0;  // requesting bytes of the word at fetch_pc
  localparam logic [1:0] StHold  = 2'd1;  // full word parked while decode is stalled
  localparam logic [1:0] StDrain = 2'd2;  // finishing a request orphaned by a redirect

  localparam logic [31:0] NopInst = 32'h0000_0013;
  localparam logic [31:0] ResetPc = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds the instruction, its pc and a valid flag for decode.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture inst_i/pc_i as a valid instruction (highest priority)
//   hold_i        : keep the current contents
//   bubble_i      : replace with NOP_INST, valid=0, pc unchanged
//   inst_o/pc_o/valid_o : registered contents
module if_fetch_stage_if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic        hold_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic        valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inst_q  <= NOP_INST;
      pc_q    <= 32'd0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      inst_q  <= inst_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end else if (hold_i) begin
      inst_q  <= inst_q;
      pc_q    <= pc_q;
      valid_q <= valid_q;
    end else if (bubble_i) begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: reads RV32I words one byte at a time (little-endian) from a
// byte-wide memory port and hands them to decode through the IF/ID register.
//   clk, rst (async, active-low)
//   stall_i                  : decode cannot accept; hold IF/ID
//   jb_taken_i, jb_target_i  : one-cycle redirect to a new fetch address
//   mem_re_o, mem_addr_o     : byte read request, stable until mem_ready_i
//   mem_ready_i, mem_data_i  : byte completion
//   inst_IFID_o, pc_IFID_o, valid_IFID_o : IF/ID contents presented to decode
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPc,
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jb_taken_i,
  input  logic [31:0] jb_target_i,
  output logic        mem_re_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] inst_IFID_o,
  output logic [31:0] pc_IFID_o,
  output logic        valid_IFID_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] drain_addr_q, drain_addr_d;

  logic [31:0] req_addr;
  logic [31:0] word;
  logic        hs;
  logic        load;
  logic [31:0] load_inst;

  // Target is always word aligned; the low bits are dropped on purpose.
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^jb_target_i[1:0];

  assign req_addr   = fetch_pc_q + {30'd0, cnt_q};
  assign mem_re_o   = rst & (state_q != StHold);
  // A drained request keeps its original address even though fetch_pc already moved.
  assign mem_addr_o = (state_q == StDrain) ? drain_addr_q : req_addr;
  assign hs         = mem_re_o & mem_ready_i;
  assign word       = {mem_data_i, asm_q};

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    pending_d    = pending_q;
    drain_addr_d = drain_addr_q;
    load         = 1'b0;
    load_inst    = word;

    if (jb_taken_i) begin
      // Redirect wins over everything on the fetch side; partial/pending words are lost.
      fetch_pc_d = {jb_target_i[31:2], 2'b00};
      cnt_d      = 2'd0;
      case (state_q)
        StFetch: begin
          if (!hs) begin
            state_d      = StDrain;
            drain_addr_d = req_addr;
          end else begin
            state_d = StFetch;
          end
        end
        StDrain: state_d = hs ? StFetch : StDrain;
        default: state_d = StFetch;
      endcase
    end else begin
      case (state_q)
        StFetch: begin
          if (hs) begin
            if (cnt_q != 2'd3) begin
              case (cnt_q)
                2'd0:    asm_d[7:0]   = mem_data_i;
                2'd1:    asm_d[15:8]  = mem_data_i;
                default: asm_d[23:16] = mem_data_i;
              endcase
              cnt_d = cnt_q + 2'd1;
            end else if (!stall_i) begin
              load       = 1'b1;
              load_inst  = word;
              fetch_pc_d = fetch_pc_q + 32'd4;
              cnt_d      = 2'd0;
            end else begin
              pending_d = word;
              state_d   = StHold;
            end
          end
        end
        StHold: begin
          if (!stall_i) begin
            load       = 1'b1;
            load_inst  = pending_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            cnt_d      = 2'd0;
            state_d    = StFetch;
          end
        end
        StDrain: begin
          if (hs) state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StFetch;
      fetch_pc_q   <= RESET_PC;
      cnt_q        <= 2'd0;
      asm_q        <= 24'd0;
      pending_q    <= NOP_INST;
      drain_addr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      pending_q    <= pending_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  if_fetch_stage_if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk_i    (clk),
    .rst_ni   (rst),
    .load_i   (load),
    .bubble_i (~stall_i),
    .hold_i   (stall_i),
    .inst_i   (load_inst),
    .pc_i     (fetch_pc_q),
    .inst_o   (inst_IFID_o),
    .pc_o     (pc_IFID_o),
    .valid_o  (valid_IFID_o)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: byte memory responder with configurable wait states, a
// word-level reference model checked every cycle, and directed literal expectations.
module tb_if_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i = 1'b0;
  logic        jb_taken_i = 1'b0;
  logic [31:0] jb_target_i = 32'd0;
  logic        mem_re_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i = 1'b0;
  logic [7:0]  mem_data_i = 8'd0;
  logic [31:0] inst_IFID_o;
  logic [31:0] pc_IFID_o;
  logic        valid_IFID_o;

  int n_checks = 0;
  int n_pass   = 0;
  int ws       = 0;    // memory wait states
  int wcnt     = 0;
  bit spurious = 1'b0; // drive mem_ready_i even without a request

  if_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .jb_taken_i   (jb_taken_i),
    .jb_target_i  (jb_target_i),
    .mem_re_o     (mem_re_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ready_i  (mem_ready_i),
    .mem_data_i   (mem_data_i),
    .inst_IFID_o  (inst_IFID_o),
    .pc_IFID_o    (pc_IFID_o),
    .valid_IFID_o (valid_IFID_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      32'd4:   return 8'h93;
      32'd5:   return 8'h05;
      32'd6:   return 8'h20;
      32'd7:   return 8'h00;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Memory responder: answers after ws idle cycles of a request.
  initial forever begin
    @(negedge clk);
    if (mem_re_o === 1'b1) begin
      if (wcnt >= ws) begin
        mem_ready_i = 1'b1;
        mem_data_i  = mem_rd(mem_addr_o);
        wcnt        = 0;
      end else begin
        mem_ready_i = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready_i = spurious;
      mem_data_i  = 8'hEE;
      wcnt        = 0;
    end
  end

  // Reference model: bytes gathered toward the word at m_pc, a parked word waiting on
  // stall, and an orphaned request still being drained after a redirect.
  logic [31:0] m_pc = 32'd0;
  int          m_n = 0;
  logic [31:0] m_word = 32'd0;
  bit          m_wait = 1'b0;
  bit          m_drain = 1'b0;
  logic [31:0] m_daddr = 32'd0;
  logic [31:0] e_inst = Nop;
  logic [31:0] e_pc = 32'd0;
  bit          e_valid = 1'b0;
  bit          m_hs;
  bit          m_deliver;

  initial forever begin
    @(posedge clk or negedge rst);
    if (rst !== 1'b1) begin
      m_pc = 32'd0; m_n = 0; m_word = 32'd0; m_wait = 1'b0; m_drain = 1'b0;
      e_inst = Nop; e_pc = 32'd0; e_valid = 1'b0;
    end else begin
      m_hs      = !m_wait && mem_ready_i;
      m_deliver = 1'b0;
      if (jb_taken_i) begin
        if (m_drain) m_drain = !m_hs;
        else if (!m_wait && !m_hs) begin
          m_drain = 1'b1;
          m_daddr = m_pc + 32'(m_n);
        end
        m_pc = {jb_target_i[31:2], 2'b00};
        m_n = 0; m_word = 32'd0; m_wait = 1'b0;
      end else if (m_drain) begin
        if (m_hs) m_drain = 1'b0;
      end else if (m_wait) begin
        if (!stall_i) m_deliver = 1'b1;
      end else if (m_hs) begin
        m_word = m_word | (32'(mem_data_i) << (8 * m_n));
        m_n++;
        if (m_n == 4) begin
          if (!stall_i) m_deliver = 1'b1;
          else m_wait = 1'b1;
        end
      end
      if (m_deliver) begin
        e_inst = m_word; e_pc = m_pc; e_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_n = 0; m_word = 32'd0; m_wait = 1'b0;
      end else if (!stall_i) begin
        e_inst = Nop; e_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("model re", 32'(mem_re_o), 32'(rst && !m_wait));
    if (rst && !m_wait) chk("model addr", mem_addr_o, m_drain ? m_daddr : m_pc + 32'(m_n));
    chk("model inst", inst_IFID_o, e_inst);
    chk("model pc", pc_IFID_o, e_pc);
    chk("model valid", 32'(valid_IFID_o), 32'(e_valid));
  end

  task automatic wait_addr(input logic [31:0] a, input int budget, input string name);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk); #1;
      if (mem_re_o === 1'b1 && mem_addr_o === a) found = 1'b1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset re", 32'(mem_re_o), 32'd0);
    chk("reset inst", inst_IFID_o, Nop);
    chk("reset pc", pc_IFID_o, 32'd0);
    chk("reset valid", 32'(valid_IFID_o), 32'd0);

    // Zero-wait fetch of the first word.
    @(posedge clk); #2 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("first addr", mem_addr_o, 32'(k));
      chk("first re", 32'(mem_re_o), 32'd1);
    end
    @(negedge clk); #1;
    chk("first inst", inst_IFID_o, 32'h0010_0513);
    chk("first pc", pc_IFID_o, 32'd0);
    chk("first valid", 32'(valid_IFID_o), 32'd1);
    chk("second addr", mem_addr_o, 32'd4);

    // Stall across completion of the word at pc 4; spurious ready while in HOLD.
    stall_i = 1'b1; spurious = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("stall hold inst", inst_IFID_o, 32'h0010_0513);
    chk("stall hold valid", 32'(valid_IFID_o), 32'd1);
    @(negedge clk); #1;
    chk("hold re", 32'(mem_re_o), 32'd0);
    chk("hold pc", pc_IFID_o, 32'd0);
    stall_i = 1'b0;
    @(negedge clk); #1;
    chk("release inst", inst_IFID_o, 32'h0020_0593);
    chk("release pc", pc_IFID_o, 32'd4);
    chk("release valid", 32'(valid_IFID_o), 32'd1);
    chk("release addr", mem_addr_o, 32'd8);
    spurious = 1'b0;

    // Redirect with byte 1 outstanding on a 2-wait-state memory.
    @(posedge clk); #2 ws = 2;
    wait_addr(32'd9, 3, "wait addr 9");
    jb_taken_i = 1'b1; jb_target_i = 32'h0000_0103;
    @(posedge clk); #1 jb_taken_i = 1'b0;
    @(negedge clk); #1;
    chk("drain addr", mem_addr_o, 32'd9);
    chk("drain re", 32'(mem_re_o), 32'd1);
    chk("drain inst", inst_IFID_o, Nop);
    chk("drain valid", 32'(valid_IFID_o), 32'd0);
    wait_addr(32'h0000_0100, 6, "after drain addr");

    // Redirect coinciding with completion of the 4th byte.
    @(posedge clk); #2 ws = 0;
    wait_addr(32'h0000_0103, 12, "wait addr 103");
    jb_taken_i = 1'b1; jb_target_i = 32'h0000_0200;
    @(posedge clk); #1 jb_taken_i = 1'b0;
    @(negedge clk); #1;
    chk("drop addr", mem_addr_o, 32'h0000_0200);
    chk("drop inst", inst_IFID_o, Nop);
    chk("drop valid", 32'(valid_IFID_o), 32'd0);

    // Wrap-around at the top of the address space; low target bits ignored.
    jb_taken_i = 1'b1; jb_target_i = 32'hFFFF_FFFE;
    @(posedge clk); #1 jb_taken_i = 1'b0;
    wait_addr(32'hFFFF_FFFC, 2, "wrap addr FC");
    wait_addr(32'hFFFF_FFFD, 2, "wrap addr FD");
    wait_addr(32'hFFFF_FFFE, 2, "wrap addr FE");
    wait_addr(32'hFFFF_FFFF, 2, "wrap addr FF");
    wait_addr(32'h0000_0000, 2, "wrap addr 0");
    chk("wrap inst", inst_IFID_o, 32'hA5A4_A7A6);
    chk("wrap pc", pc_IFID_o, 32'hFFFF_FFFC);
    chk("wrap valid", 32'(valid_IFID_o), 32'd1);

    // Asynchronous reset in the middle of a word (cnt = 2).
    wait_addr(32'd1, 2, "pre-reset addr 1");
    wait_addr(32'd2, 2, "pre-reset addr 2");
    #2 rst = 1'b0;
    #1;
    chk("async re", 32'(mem_re_o), 32'd0);
    chk("async inst", inst_IFID_o, Nop);
    chk("async pc", pc_IFID_o, 32'd0);
    chk("async valid", 32'(valid_IFID_o), 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    for (int k = 0; k < 4; k++) wait_addr(32'(k), 1, "restart addr");
    @(negedge clk); #1;
    chk("restart inst", inst_IFID_o, 32'h0010_0513);
    chk("restart valid", 32'(valid_IFID_o), 32'd1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
